uart_tx_queue: RTL and testbench
================================

Name: uart_tx_queue

Overview:
- Transmit-side buffer that sits directly upstream of uart_top.
- Accepts 9-bit words from a host through a valid/ready interface and stores them in a circular FIFO.
- Feeds the words to uart_top one at a time, using uart_top's request/ready handshake.
- Lets the host post bursts without polling UART readiness word by word.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- DATA_W, 9, word width; matches uart_top i_data.
- GUARD, 8, cycles to wait for the UART to drop ready after a request before FSM returns to IDLE.

Ports:
- i_clk  in  1  sole clock, rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_wr_valid  in  1  host word valid.
- o_wr_ready  out  1  queue can accept a word.
- i_wr_data  in  DATA_W  host word.
- i_flush  in  1  discard all queued words.
- i_uart_ready  in  1  from uart_top o_ready.
- o_request_tx  out  1  to uart_top i_request_tx; single-cycle pulse.
- o_tx_data  out  DATA_W  to uart_top i_data.
- o_count  out  $clog2(DEPTH)+1  words currently queued.
- o_empty  out  1  count==0.
- o_full  out  1  count==DEPTH.
- o_overflow  out  1  sticky; set when i_wr_valid is high while o_wr_ready is low.

Behaviour:
- Clock and reset: one clock, i_clk; reset i_rst is synchronous and active-high. All state changes on the rising edge of i_clk.
- Reset values:
  - o_request_tx=0, o_tx_data=0, o_count=0, o_empty=1, o_full=0, o_overflow=0, o_wr_ready=1.
  - Read/write pointers=0; FSM=IDLE; guard counter=0.
- Write side:
  - o_wr_ready = !o_full && !i_flush (combinational from registered full).
  - Push occurs when i_wr_valid && o_wr_ready. The word is stored at the write pointer; pointer wraps DEPTH-1 -> 0.
  - When full, no write is accepted, even if a pop happens the same cycle.
  - o_overflow sets on any i_wr_valid && !o_wr_ready. It clears only on reset.
- Count: +1 on push only, -1 on pop only, unchanged on push and pop together. o_empty and o_full are registered and consistent with o_count every cycle.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
  - IDLE: if !o_empty && i_uart_ready && !i_flush -> ISSUE.
    - On that edge: pop head into o_tx_data, advance read pointer, decrement count.
  - ISSUE: o_request_tx=1 for exactly this one cycle; o_tx_data stable. Next state is WAIT_BUSY; guard counter cleared.
  - WAIT_BUSY:
    - If i_uart_ready==0 -> WAIT_DONE.
    - Otherwise the guard counter increments; at GUARD -> IDLE, on the basis that the UART accepted the word and finished.
  - WAIT_DONE: wait for i_uart_ready==1 -> IDLE.
- Latency: a word written into an empty queue while the UART is idle appears as o_request_tx 2 cycles after the write edge (write edge, then IDLE->ISSUE edge).
- Next-word spacing: at least 1 IDLE cycle between consecutive requests.
- o_tx_data holds the last issued word until the next pop; it is never updated outside the IDLE->ISSUE edge.
- Flush:
  - Resets pointers and count to 0 in one cycle; o_empty=1.
  - Does not affect the FSM, so an in-flight word completes normally.
  - Flush and push in the same cycle: flush wins and the write is not accepted (o_wr_ready low).
  - Flush in IDLE blocks the pop that cycle.
- Reset mid-operation: FSM returns to IDLE at once and o_request_tx drops; queued words are lost. The UART frame in progress is not tracked.

Decomposition:
- Package uart_pkg:
  - UART_DATA_W=9.
  - typedef uart_word_t (logic [8:0]).
  - enum tx_queue_state_t {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE}.
- Sub-module uart_sync_fifo:
  - Parameters: DEPTH, DATA_W.
  - Behaviour: push/pop/flush, count/full/empty.
  - Reused later for an RX-side queue.
- uart_tx_queue instantiates uart_sync_fifo plus the issue FSM and guard counter.

Test Plan:
- Reset: assert i_rst 3 cycles -> o_empty=1, o_count=0, o_wr_ready=1, o_request_tx=0, o_overflow=0.
- Single word: with uart_top looped back (i_uart_ready from o_ready), write 0x0A5 -> o_request_tx pulses once, 2 cycles later, with o_tx_data=0x0A5. The UART loopback receives 0x0A5 and o_empty=1.
- Burst and order: write 0x011, 0x022, 0x033, 0x044 back-to-back -> four single-cycle requests in that order. Each request occurs only after i_uart_ready returns to 1; loopback receives the same sequence.
- Full/overflow:
  - Hold i_uart_ready=0 and write DEPTH+1 words (0x100..0x110) -> o_full=1, o_count=16, o_wr_ready=0, o_overflow=1.
  - Release ready -> exactly 16 words sent, 0x110 never sent.
- Flush mid-frame: queue 0x0F0, 0x0F1, 0x0F2, and pulse i_flush while the first word is in WAIT_DONE -> only 0x0F0 transmitted, o_count=0.
- Guard timeout: tie i_uart_ready=1, write 0x055 -> one request pulse, FSM back in IDLE after GUARD=8 cycles, then a second queued word 0x056 is issued.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART transmit/receive queue blocks.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 9;

  typedef logic [UART_DATA_W-1:0] uart_word_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } tx_queue_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock circular FIFO with flush; head word is visible combinationally.
module uart_sync_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata_c,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count_nxt;
  logic              push_ok;
  logic              pop_ok;

  // Flush takes priority over both ends of the queue.
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign rdata_c = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop_ok) begin
      count_nxt = count + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_nxt = count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_nxt;
      empty <= (count_nxt == CW'(0));
      full  <= (count_nxt == CW'(DEPTH));
    end
  end

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Host-facing transmit queue that feeds uart_top one word at a time
// through its request/ready handshake.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = UART_DATA_W,
  parameter int unsigned GUARD  = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_wr_valid,
  output logic                   o_wr_ready,
  input  logic [DATA_W-1:0]      i_wr_data,
  input  logic                   i_flush,
  input  logic                   i_uart_ready,
  output logic                   o_request_tx,
  output logic [DATA_W-1:0]      o_tx_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty,
  output logic                   o_full,
  output logic                   o_overflow
);

  localparam int unsigned GW = $clog2(GUARD + 1);

  tx_queue_state_t   state;
  tx_queue_state_t   state_nxt;
  logic [GW-1:0]     guard;
  logic [GW-1:0]     guard_nxt;
  logic              req_nxt;
  logic              pop_c;
  logic [DATA_W-1:0] head_c;

  assign o_wr_ready = !o_full && !i_flush;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (i_clk),
    .rst     (i_rst),
    .push    (i_wr_valid),
    .pop     (pop_c),
    .flush   (i_flush),
    .wdata   (i_wr_data),
    .rdata_c (head_c),
    .count   (o_count),
    .full    (o_full),
    .empty   (o_empty)
  );

  // Issue FSM: pop on the IDLE->ISSUE edge, then track the UART busy window.
  always_comb begin
    state_nxt = state;
    guard_nxt = guard;
    req_nxt   = 1'b0;
    pop_c     = 1'b0;
    case (state)
      IDLE: begin
        if (!o_empty && i_uart_ready && !i_flush) begin
          state_nxt = ISSUE;
          pop_c     = 1'b1;
          req_nxt   = 1'b1;
        end
      end
      ISSUE: begin
        state_nxt = WAIT_BUSY;
        guard_nxt = '0;
      end
      WAIT_BUSY: begin
        if (!i_uart_ready) begin
          state_nxt = WAIT_DONE;
        end else if (guard == GW'(GUARD - 1)) begin
          // UART never showed busy; assume it took the word and finished.
          state_nxt = IDLE;
          guard_nxt = GW'(GUARD);
        end else begin
          guard_nxt = guard + GW'(1);
        end
      end
      WAIT_DONE: begin
        if (i_uart_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      guard        <= '0;
      o_request_tx <= 1'b0;
      o_tx_data    <= '0;
      o_overflow   <= 1'b0;
    end else begin
      state        <= state_nxt;
      guard        <= guard_nxt;
      o_request_tx <= req_nxt;
      if (pop_c) begin
        o_tx_data <= head_c;
      end
      if (i_wr_valid && !o_wr_ready) begin
        o_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed + randomized bench for uart_tx_queue with a behavioural UART and
// a word-order scoreboard.
module tb_uart_tx_queue;

  localparam int DEPTH = 16;
  localparam int GUARD = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic       wr_ready;
  logic [8:0] wr_data;
  logic       flush;
  logic       uart_ready;
  logic       request_tx;
  logic [8:0] tx_data;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       overflow;

  uart_tx_queue dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_wr_valid   (wr_valid),
    .o_wr_ready   (wr_ready),
    .i_wr_data    (wr_data),
    .i_flush      (flush),
    .i_uart_ready (uart_ready),
    .o_request_tx (request_tx),
    .o_tx_data    (tx_data),
    .o_count      (count),
    .o_empty      (empty),
    .o_full       (full),
    .o_overflow   (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // UART model: 0 = held busy, 1 = frames of random length, 2 = ready tied high
  int         umode = 0;
  logic [8:0] rx_q[$];
  int         req_cyc[$];
  int         proto_err = 0;
  bit         model_busy = 0;
  bit         prev_req = 0;
  int         delay_left = 0;
  int         busy_left = 0;

  initial begin
    uart_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (request_tx === 1'b1) begin
        if (prev_req || model_busy) proto_err++;
        rx_q.push_back(tx_data);
        req_cyc.push_back(cyc);
        if (umode == 1) begin
          model_busy = 1;
          delay_left = $urandom_range(0, 2);
          busy_left  = $urandom_range(3, 8);
        end
      end
      prev_req = (request_tx === 1'b1);
      if (umode == 0) begin
        uart_ready = 1'b0;
        model_busy = 0;
      end else if (umode == 2) begin
        uart_ready = 1'b1;
        model_busy = 0;
      end else if (model_busy) begin
        if (delay_left > 0) delay_left--;
        else if (busy_left > 0) begin
          uart_ready = 1'b0;
          busy_left--;
        end else begin
          uart_ready = 1'b1;
          model_busy = 0;
        end
      end else begin
        uart_ready = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [8:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget, input string tag);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      step();
      k++;
    end
    chk(tag, rx_q.size(), n);
  endtask

  task automatic settle();
    int k = 0;
    while ((model_busy || !empty) && k < 500) begin
      step();
      k++;
    end
    repeat (GUARD + 6) step();
  endtask

  logic [8:0] exp_q[$];
  int         base;
  int         w;
  int         n;
  logic [8:0] d;

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; flush = 1'b0;
    repeat (3) step();
    chk("reset_empty", empty, 1);
    chk("reset_count", count, 0);
    chk("reset_wr_ready", wr_ready, 1);
    chk("reset_request", request_tx, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_full", full, 0);
    rst = 1'b0;
    umode = 1;
    repeat (2) step();

    // single word: request two edges after the write edge
    push(9'h0A5);
    w = cyc;
    wait_rx(1, 60, "single_rx_count");
    chk("single_latency", req_cyc[0], w + 1);
    chk("single_word", rx_q[0], 9'h0A5);
    settle();
    chk("single_empty", empty, 1);
    chk("single_tx_hold", tx_data, 9'h0A5);

    // burst, order preserved
    base = rx_q.size();
    exp_q = '{9'h011, 9'h022, 9'h033, 9'h044};
    foreach (exp_q[i]) push(exp_q[i]);
    wait_rx(base + 4, 300, "burst_rx_count");
    for (int i = 0; i < 4; i++) chk("burst_word", rx_q[base + i], exp_q[i]);
    for (int i = 1; i < 4; i++)
      chk("burst_spacing_ge2", (req_cyc[base + i] - req_cyc[base + i - 1]) >= 2, 1);
    settle();

    // randomized traffic with random gaps
    base = rx_q.size();
    exp_q = {};
    n = $urandom_range(6, 12);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) step();
      d = 9'($urandom_range(0, 511));
      if (wr_ready) begin
        exp_q.push_back(d);
        push(d);
      end
    end
    wait_rx(base + exp_q.size(), 600, "rand_rx_count");
    foreach (exp_q[i]) chk("rand_word", rx_q[base + i], exp_q[i]);
    settle();

    // fill past DEPTH with the UART held busy
    umode = 0;
    repeat (2) step();
    base = rx_q.size();
    wr_valid = 1'b1;
    for (int i = 0; i <= DEPTH; i++) begin
      wr_data = 9'(9'h100 + i);
      step();
    end
    wr_valid = 1'b0;
    chk("full_flag", full, 1);
    chk("full_count", count, DEPTH);
    chk("full_wr_ready", wr_ready, 0);
    chk("full_overflow", overflow, 1);
    chk("full_no_request", rx_q.size(), base);
    umode = 1;
    wait_rx(base + DEPTH, 800, "full_rx_count");
    repeat (40) step();
    chk("full_exact_16", rx_q.size(), base + DEPTH);
    for (int i = 0; i < DEPTH; i++) chk("full_word", rx_q[base + i], 9'(9'h100 + i));
    chk("drain_empty", empty, 1);
    chk("overflow_sticky", overflow, 1);
    settle();

    // flush while the first word's frame is in progress; flush also blocks a write
    base = rx_q.size();
    push(9'h0F0);
    push(9'h0F1);
    push(9'h0F2);
    begin
      int k = 0;
      while (uart_ready !== 1'b0 && k < 20) begin step(); k++; end
      chk("flush_saw_busy", uart_ready, 0);
    end
    step();
    chk("flush_pre_count", count, 2);
    flush = 1'b1;
    wr_valid = 1'b1;
    wr_data = 9'h1FF;
    #1;
    chk("flush_wr_ready_low", wr_ready, 0);
    step();
    flush = 1'b0;
    wr_valid = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);
    repeat (40) step();
    chk("flush_rx_count", rx_q.size(), base + 1);
    chk("flush_word", rx_q[base], 9'h0F0);
    settle();

    // guard timeout with ready tied high
    umode = 2;
    repeat (3) step();
    base = rx_q.size();
    push(9'h055);
    w = cyc;
    push(9'h056);
    wait_rx(base + 2, 60, "guard_rx_count");
    chk("guard_latency", req_cyc[base], w + 1);
    chk("guard_spacing", req_cyc[base + 1] - req_cyc[base], GUARD + 2);
    chk("guard_word0", rx_q[base], 9'h055);
    chk("guard_word1", rx_q[base + 1], 9'h056);
    settle();

    // reset with words queued
    umode = 0;
    repeat (2) step();
    push(9'h1A1);
    push(9'h1A2);
    push(9'h1A3);
    chk("rstmid_count_pre", count, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid_count", count, 0);
    chk("rstmid_empty", empty, 1);
    chk("rstmid_overflow", overflow, 0);
    chk("rstmid_request", request_tx, 0);
    base = rx_q.size();
    umode = 1;
    repeat (30) step();
    chk("rstmid_no_tx", rx_q.size(), base);

    chk("protocol", proto_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
